// File: rtl/carry_look_ahead_adder_group4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Internal carries are flattened sums of products, so there is no ripple path.
module cla_group4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       gp,
   output logic       gg
);

   logic [3:0] g, p, c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c;

   // The carry out of this group comes from the group-level unit, which uses gp/gg.
   assign gp  = &p;
   assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered two-level carry-lookahead adder: Out = A + B + Cin (WIDTH+1 bits).
module carry_look_ahead_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH:0]   Out
);

   localparam int NG = WIDTH / 4;

   logic [NG-1:0]    gp, gg;
   logic [NG:0]      gc;
   logic [WIDTH-1:0] sum;

   if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("carry_look_ahead_adder: WIDTH must be a positive multiple of 4");
   end

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_group4 u_grp (
         .a   (A[4*gi +: 4]),
         .b   (B[4*gi +: 4]),
         .cin (gc[gi]),
         .sum (sum[4*gi +: 4]),
         .gp  (gp[gi]),
         .gg  (gg[gi])
      );
   end

   // Group carry-ins as independent product terms, one per lower group plus Cin.
   // Carry n = OR over k<n of (GG[k] & GP[k+1..n-1]), OR (Cin & GP[0..n-1]).
   always_comb begin
      logic acc;
      logic t;
      gc    = '0;
      gc[0] = Cin;
      for (int n = 1; n <= NG; n++) begin
         acc = 1'b0;
         for (int k = -1; k < n; k++) begin
            t = (k < 0) ? Cin : gg[k];
            for (int j = k + 1; j < n; j++) t = t & gp[j];
            acc = acc | t;
         end
         gc[n] = acc;
      end
   end

   // Output register; the async reset clears the result without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) Out <= '0;
      else     Out <= {gc[NG], sum};
   end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Bench for carry_look_ahead_adder: 4-bit and 16-bit instances on a shared clock.
module tb_carry_look_ahead_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  a4  = '0, b4 = '0;
   logic        c4  = 1'b0;
   logic [4:0]  o4;
   logic [15:0] a16 = '0, b16 = '0;
   logic        c16 = 1'b0;
   logic [16:0] o16;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [4:0] exp;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [16:0] exp;
   } vec16_t;

   vec_t   vecs[8];
   vec16_t v16[3];

   carry_look_ahead_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .Out(o4)
   );

   carry_look_ahead_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(c16), .Out(o16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [4:0]  prev;
      logic [16:0] e16;

      vecs[0] = '{4'h0, 4'h0, 1'b1, 5'h01};
      vecs[1] = '{4'h3, 4'h2, 1'b1, 5'h06};
      vecs[2] = '{4'h1, 4'h5, 1'b1, 5'h07};
      vecs[3] = '{4'h2, 4'h3, 1'b1, 5'h06};
      vecs[4] = '{4'h3, 4'h2, 1'b0, 5'h05};
      vecs[5] = '{4'hF, 4'h0, 1'b1, 5'h10};
      vecs[6] = '{4'h8, 4'h8, 1'b0, 5'h10};
      vecs[7] = '{4'hF, 4'hF, 1'b1, 5'h1F};

      v16[0] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
      v16[1] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
      v16[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};

      // Reset held across edges.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_o4", {12'h0, o4}, 17'h0);
      chk("reset_o16", o16, 17'h0);

      // Directed vectors back-to-back; Out must not move before the edge.
      prev = 5'h00;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) @(negedge clk);
         a4 = vecs[i].a; b4 = vecs[i].b; c4 = vecs[i].cin;
         #1;
         chk($sformatf("hold_before_edge[%0d]", i), {12'h0, o4}, {12'h0, prev});
         @(posedge clk);
         #1;
         chk($sformatf("vec[%0d]", i), {12'h0, o4}, {12'h0, vecs[i].exp});
         prev = vecs[i].exp;
      end

      // Async reset mid-cycle with F+F+1 on the inputs.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_o4", {12'h0, o4}, 17'h0);
      @(posedge clk);
      #1;
      chk("reset_held_o4", {12'h0, o4}, 17'h0);
      chk("reset_held_o16", o16, 17'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_no_edge_o4", {12'h0, o4}, 17'h0);
      @(posedge clk);
      #1;
      chk("release_first_o4", {12'h0, o4}, 17'h1F);

      // 16-bit directed group-level carries.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a16 = v16[i].a; b16 = v16[i].b; c16 = v16[i].cin;
         @(posedge clk);
         #1;
         chk($sformatf("v16[%0d]", i), o16, v16[i].exp);
      end

      // 16-bit random against behavioural sum.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         c16 = 1'($urandom);
         e16 = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
         @(posedge clk);
         #1;
         chk($sformatf("rand16[%0d] %h+%h+%0d", i, a16, b16, c16), o16, e16);
      end

      // Exhaustive 4-bit.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] iv;
         logic [4:0] e4;
         iv = 9'(i);
         @(negedge clk);
         a4 = iv[3:0]; b4 = iv[7:4]; c4 = iv[8];
         e4 = {1'b0, iv[3:0]} + {1'b0, iv[7:4]} + {4'h0, iv[8]};
         @(posedge clk);
         #1;
         chk($sformatf("exh %h+%h+%0d", a4, b4, c4), {12'h0, o4}, {12'h0, e4});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
